// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types for the PWM bank:
//   load_state_t : loader FSM states (IDLE, LOAD, PEND)
//   pwm_mode_t   : modulation alignment (EDGE, CENTER)
//   idx_width()  : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } load_state_t;

   typedef enum logic {
      EDGE   = 1'b0,
      CENTER = 1'b1
   } pwm_mode_t;

   // A single-channel bank still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// -----------------------------------------------------------------------------
// pwm_bank_if
// Control, duty-stream and status bundle of the PWM bank.
//   master modport (controller side): drives en, start, period, mode, pol,
//                                     in_valid, in_data; reads status/outputs
//   slave modport  (pwm_bank side)  : the reverse
// Signals:
//   en        run enable (0 holds timebase, forces out = pol)
//   start     one-cycle pulse that opens a load, samples period/mode
//   period    counter top P
//   mode      0 edge-aligned, 1 center-aligned
//   pol       per-channel output inversion, applied live
//   in_valid / in_data / in_ready  duty word handshake, channel 0 first
//   busy      loader not idle
//   eop       end-of-period pulse
//   updated   pulse: newly committed settings active this cycle
//   out       registered PWM outputs
// -----------------------------------------------------------------------------
interface pwm_bank_if #(
   parameter int DWIDTH   = 8,
   parameter int CHANNELS = 8
);
   logic                en;
   logic                start;
   logic [DWIDTH-1:0]   period;
   logic                mode;
   logic [CHANNELS-1:0] pol;
   logic                in_valid;
   logic [DWIDTH-1:0]   in_data;
   logic                in_ready;
   logic                busy;
   logic                eop;
   logic                updated;
   logic [CHANNELS-1:0] out;

   modport master (
      output en, start, period, mode, pol, in_valid, in_data,
      input  in_ready, busy, eop, updated, out
   );

   modport slave (
      input  en, start, period, mode, pol, in_valid, in_data,
      output in_ready, busy, eop, updated, out
   );
endinterface

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Shared period counter for all PWM channels.
//   clk, rst : clock, synchronous active-high reset
//   en       : 0 holds cnt at 0 with direction up and suppresses eop
//   period   : counter top P (active value from the bank)
//   mode     : EDGE  -> 0,1,..,P,0,..            (P+1 cycles)
//              CENTER-> 0,1,..,P,P-1,..,1,0,..   (2P cycles)
//   cnt      : current count
//   eop      : high in the cycle whose next count is 0 (period restart)
// -----------------------------------------------------------------------------
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DWIDTH-1:0] period,
   input  pwm_mode_t         mode,
   output logic [DWIDTH-1:0] cnt,
   output logic              eop
);

   localparam logic [DWIDTH-1:0] ONE = {{(DWIDTH-1){1'b0}}, 1'b1};

   logic [DWIDTH-1:0] r_cnt;
   logic [DWIDTH-1:0] w_cnt_next;
   logic              r_dir_down;
   logic              w_dir_down_next;

   always_comb begin
      w_cnt_next      = r_cnt;
      w_dir_down_next = r_dir_down;
      if (!en) begin
         w_cnt_next      = '0;
         w_dir_down_next = 1'b0;
      end else if (mode == EDGE) begin
         w_dir_down_next = 1'b0;
         // >= rather than == so a count left above a lowered top still wraps
         if (r_cnt >= period) begin
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + ONE;
         end
      end else if (r_dir_down) begin
         if (r_cnt <= ONE) begin
            w_cnt_next      = '0;
            w_dir_down_next = 1'b0;
         end else begin
            w_cnt_next = r_cnt - ONE;
         end
      end else begin
         if (r_cnt >= period) begin
            if (period == '0) begin
               w_cnt_next      = '0;
               w_dir_down_next = 1'b0;
            end else begin
               // Turn around at the top; for P=1 the next value is already 0,
               // so the direction stays up.
               w_cnt_next      = period - ONE;
               w_dir_down_next = (period != ONE);
            end
         end else begin
            w_cnt_next = r_cnt + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_dir_down <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_dir_down <= w_dir_down_next;
      end
   end

   assign cnt = r_cnt;
   assign eop = en && !rst && (w_cnt_next == '0);

endmodule

// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank
// Multi-channel PWM generator with double-buffered duty registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pwm_bank_if slave port (control, duty stream, status, outputs)
// Duty words stream into shadow registers while the loader is in LOAD; once
// all CHANNELS words are in, the loader waits in PEND and copies the shadow
// duty/period/mode into the active set on the next end-of-period, so every
// channel switches on the same period boundary.
// -----------------------------------------------------------------------------
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int DWIDTH   = 8,
   parameter int CHANNELS = 8
) (
   input  logic     clk,
   input  logic     rst,
   pwm_bank_if.slave bus
);

   localparam int                IDX_W    = idx_width(CHANNELS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

   // Loader state and shadow settings
   load_state_t       r_state;
   load_state_t       w_state_next;
   logic [IDX_W-1:0]  r_idx;
   logic [DWIDTH-1:0] r_shadow_period;
   pwm_mode_t         r_shadow_mode;

   // Active settings driving the timebase
   logic [DWIDTH-1:0] r_active_period;
   pwm_mode_t         r_active_mode;

   logic              r_updated;
   logic [DWIDTH-1:0] w_cnt;
   logic              w_eop;
   logic              w_start_ok;
   logic              w_accept;
   logic              w_commit;
   logic              w_in_ready;
   logic              w_busy;
   logic [CHANNELS-1:0] w_out;

   // -------------------------------------------------------------------------
   // Loader FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Loader FSM: next state and decoded strobes
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_start_ok   = 1'b0;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      w_in_ready   = 1'b0;
      w_busy       = 1'b1;
      unique case (r_state)
         IDLE: begin
            w_busy     = 1'b0;
            w_start_ok = bus.start;
            if (bus.start) begin
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            // start is deliberately ignored here and in PEND
            w_in_ready = 1'b1;
            w_accept   = bus.in_valid;
            if (bus.in_valid && (r_idx == LAST_IDX)) begin
               w_state_next = PEND;
            end
         end
         PEND: begin
            // eop is already gated by en, so a commit waits for en=1
            w_commit = w_eop;
            if (w_eop) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Word index, shadow/active period and mode, update pulse
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx           <= '0;
         r_shadow_period <= '1;
         r_shadow_mode   <= EDGE;
         r_active_period <= '1;
         r_active_mode   <= EDGE;
         r_updated       <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_idx           <= '0;
            r_shadow_period <= bus.period;
            r_shadow_mode   <= pwm_mode_t'(bus.mode);
         end else if (w_accept) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_ONE;
         end
         if (w_commit) begin
            r_active_period <= r_shadow_period;
            r_active_mode   <= r_shadow_mode;
         end
         r_updated <= w_commit;
      end
   end

   // -------------------------------------------------------------------------
   // Shared timebase
   // -------------------------------------------------------------------------
   pwm_timebase #(
      .DWIDTH (DWIDTH)
   ) u_timebase (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en),
      .period (r_active_period),
      .mode   (r_active_mode),
      .cnt    (w_cnt),
      .eop    (w_eop)
   );

   // -------------------------------------------------------------------------
   // Per-channel shadow/active duty and registered compare
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [DWIDTH-1:0] r_shadow_duty;
         logic [DWIDTH-1:0] r_active_duty;
         logic              r_out;
         logic              w_raw;

         // cnt < duty covers both modes: duty=0 never fires, duty>P always does
         assign w_raw = (w_cnt < r_active_duty);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_shadow_duty <= '0;
               r_active_duty <= '0;
               r_out         <= 1'b0;
            end else begin
               if (w_accept && (r_idx == IDX_W'(gi))) begin
                  r_shadow_duty <= bus.in_data;
               end
               if (w_commit) begin
                  r_active_duty <= r_shadow_duty;
               end
               r_out <= bus.en ? (w_raw ^ bus.pol[gi]) : bus.pol[gi];
            end
         end

         assign w_out[gi] = r_out;
      end
   endgenerate

   assign bus.in_ready = w_in_ready;
   assign bus.busy     = w_busy;
   assign bus.eop      = w_eop;
   assign bus.updated  = r_updated;
   assign bus.out      = w_out;

endmodule

// File: tb/tb_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_bank
// Scoreboard bench for pwm_bank (DWIDTH=8, CHANNELS=4). The stimulus process
// pushes expectations into queues; a monitor on the falling edge pops them:
//   snap_q : expected status/output levels for the current cycle
//   rec_q  : expected period records (length, high cycles per channel),
//            compared each time a period of 'out' completes
//   upd_q  : expected eop count at which 'updated' must pulse
// -----------------------------------------------------------------------------
module tb_pwm_bank;
   import pwm_pkg::*;

   localparam int DW = 8;
   localparam int CH = 4;

   localparam logic [4:0] M_OUT  = 5'b00001;
   localparam logic [4:0] M_BUSY = 5'b00010;
   localparam logic [4:0] M_RDY  = 5'b00100;
   localparam logic [4:0] M_EOP  = 5'b01000;
   localparam logic [4:0] M_UPD  = 5'b10000;
   localparam logic [4:0] M_ALL  = 5'b11111;

   typedef struct {
      string         name;
      logic [4:0]    mask;
      logic [CH-1:0] out;
      logic          busy;
      logic          rdy;
      logic          eop;
      logic          upd;
      bit            timeout;
   } snap_t;

   typedef struct {
      string               name;
      int                  len;
      logic [CH-1:0][15:0] hi;
   } rec_t;

   logic clk;
   logic rst;

   snap_t snap_q[$];
   rec_t  rec_q[$];
   int    upd_q[$];

   int checks  = 0;
   int errors  = 0;
   int eop_cnt = 0;
   bit done    = 0;

   pwm_bank_if #(.DWIDTH(DW), .CHANNELS(CH)) bus ();

   pwm_bank #(.DWIDTH(DW), .CHANNELS(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(input string nm, input logic [4:0] m, input logic [CH-1:0] o,
                       input logic b, input logic r, input logic e, input logic u);
      snap_t s;
      s.name = nm; s.mask = m; s.out = o; s.busy = b; s.rdy = r;
      s.eop = e; s.upd = u; s.timeout = 1'b0;
      snap_q.push_back(s);
   endtask

   task automatic timeout(input string nm);
      snap_t s;
      s.name = nm; s.mask = '0; s.out = '0; s.busy = 1'b0; s.rdy = 1'b0;
      s.eop = 1'b0; s.upd = 1'b0; s.timeout = 1'b1;
      snap_q.push_back(s);
   endtask

   task automatic rec(input string nm, input int len, input int h0, input int h1,
                      input int h2, input int h3);
      rec_t r;
      r.name = nm; r.len = len;
      r.hi[0] = 16'(h0); r.hi[1] = 16'(h1); r.hi[2] = 16'(h2); r.hi[3] = 16'(h3);
      rec_q.push_back(r);
   endtask

   task automatic do_start(input int p, input logic m);
      bus.start  = 1'b1;
      bus.period = 8'(p);
      bus.mode   = m;
      tick();
      bus.start  = 1'b0;
      snap("start_ack", M_BUSY | M_RDY, '0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic send_word(input int d);
      bit ok;
      ok = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(d);
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin
            ok = 1;
            tick();
            break;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      if (!ok) timeout("word_ready_wait");
   endtask

   task automatic send4(input int d0, input int d1, input int d2, input int d3);
      send_word(d0);
      send_word(d1);
      send_word(d2);
      send_word(d3);
      snap("last_word", M_BUSY | M_RDY, '0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_updated(input string nm, input int limit);
      bit found;
      found = 0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (bus.updated) begin
            found = 1;
            break;
         end
      end
      if (!found) timeout(nm);
   endtask

   task automatic drain(input string nm, input int limit);
      bit empty;
      empty = 0;
      for (int i = 0; i < limit; i++) begin
         if (rec_q.size() == 0) begin
            empty = 1;
            break;
         end
         tick();
      end
      if (!empty) begin
         rec_q.delete();
         timeout(nm);
      end
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin : stim
      bit found;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.start    = 1'b0;
      bus.period   = '0;
      bus.mode     = 1'b0;
      bus.pol      = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tick();
      tick();
      snap("reset_state", M_ALL, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Free-running with reset settings: P=255, all duties 0
      rst    = 1'b0;
      bus.en = 1'b1;
      rec("idle_period", 256, 0, 0, 0, 0);
      rec("idle_period", 256, 0, 0, 0, 0);
      drain("idle_drain", 700);

      // Edge-aligned load
      do_start(9, 1'b0);
      send4(0, 3, 9, 10);
      wait_updated("edge_updated_wait", 300);
      tick();
      rec("edge_p9", 10, 0, 3, 9, 10);
      rec("edge_p9", 10, 0, 3, 9, 10);
      drain("edge_drain", 100);

      // Center-aligned load
      do_start(4, 1'b1);
      send4(2, 4, 1, 5);
      wait_updated("center_updated_wait", 100);
      tick();
      rec("center_p4", 8, 3, 7, 1, 8);
      rec("center_p4", 8, 3, 7, 1, 8);
      drain("center_drain", 100);

      // Last word accepted on an eop cycle: commit waits one more period
      do_start(5, 1'b0);
      send_word(1);
      send_word(2);
      send_word(6);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.eop) begin
            found = 1;
            break;
         end
         tick();
      end
      if (!found) timeout("eop_wait");
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd0;
      rec("hold_old", 8, 3, 7, 1, 8);
      rec("hold_old", 8, 3, 7, 1, 8);
      upd_q.push_back(eop_cnt + 2);
      tick();
      bus.in_valid = 1'b0;
      snap("last_word_on_eop", M_BUSY | M_RDY, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_updated("late_updated_wait", 40);
      snap("upd_out_old", M_OUT | M_UPD | M_BUSY, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      snap("upd_out_new", M_OUT | M_UPD, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      rec("edge_p5", 6, 1, 2, 6, 0);
      rec("edge_p5", 6, 1, 2, 6, 0);
      drain("late_drain", 100);

      // Backpressure and ignored restart
      bus.pol = 4'b0010;
      do_start(7, 1'b0);
      send_word(7);
      send_word(0);
      for (int i = 0; i < 5; i++) begin
         bus.start  = (i == 2);
         bus.period = 8'd2;
         bus.mode   = 1'b1;
         tick();
         snap($sformatf("stall_%0d", i), M_BUSY | M_RDY, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      bus.start = 1'b0;
      send_word(8);
      send_word(3);
      snap("last_word", M_BUSY | M_RDY, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_updated("stall_updated_wait", 100);
      tick();
      rec("stall_p7_pol", 8, 7, 8, 8, 3);
      rec("stall_p7_pol", 8, 7, 8, 8, 3);
      drain("stall_drain", 100);

      // en=0 forces out=pol and suppresses eop; loader still works
      bus.pol = 4'b0101;
      bus.en  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         snap($sformatf("en0_%0d", i), M_OUT | M_EOP, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      do_start(3, 1'b0);
      send4(3, 3, 3, 3);
      repeat (8) tick();
      snap("pend_wait_en0", M_OUT | M_BUSY | M_UPD, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset while pending discards the shadow and restores reset settings
      rst = 1'b1;
      tick();
      tick();
      snap("rst_in_pend", M_ALL, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      rst     = 1'b0;
      bus.en  = 1'b1;
      bus.pol = 4'b0000;
      rec("after_rst", 256, 0, 0, 0, 0);
      drain("after_rst_drain", 400);

      done = 1'b1;
      repeat (5) tick();
   end

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      snap_t               s;
      rec_t                r;
      int                  exp_e;
      int                  acc_len;
      logic [CH-1:0][15:0] acc_hi;
      logic                eop_d;
      logic                en_prev;
      logic [4:0]          bad;
      bit                  rec_bad;
      int                  left;

      acc_len = 0;
      acc_hi  = '0;
      eop_d   = 1'b0;
      en_prev = 1'b0;
      forever begin
         @(negedge clk);

         while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            checks++;
            if (s.timeout) begin
               errors++;
               $display("FAIL %s: wait bound expired, got no DUT event, required one", s.name);
            end else begin
               bad    = '0;
               bad[0] = s.mask[0] && (bus.out      !== s.out);
               bad[1] = s.mask[1] && (bus.busy     !== s.busy);
               bad[2] = s.mask[2] && (bus.in_ready !== s.rdy);
               bad[3] = s.mask[3] && (bus.eop      !== s.eop);
               bad[4] = s.mask[4] && (bus.updated  !== s.upd);
               if (bad != '0) begin
                  errors++;
                  $display("FAIL %s: got out=%b busy=%b in_ready=%b eop=%b updated=%b, expected out=%b busy=%b in_ready=%b eop=%b updated=%b (mask %b)",
                           s.name, bus.out, bus.busy, bus.in_ready, bus.eop, bus.updated,
                           s.out, s.busy, s.rdy, s.eop, s.upd, s.mask);
               end
            end
         end

         if (bus.updated === 1'b1 && upd_q.size() > 0) begin
            exp_e = upd_q.pop_front();
            checks++;
            if (eop_cnt != exp_e) begin
               errors++;
               $display("FAIL updated_timing: got updated after eop #%0d, expected after eop #%0d",
                        eop_cnt, exp_e);
            end
         end

         if (rst) begin
            acc_len = 0;
            acc_hi  = '0;
            eop_d   = 1'b0;
            en_prev = 1'b0;
         end else begin
            // out lags cnt by one cycle, so a period of out closes the
            // cycle after eop
            if (!en_prev) begin
               acc_len = 0;
               acc_hi  = '0;
            end else begin
               acc_len++;
               for (int c = 0; c < CH; c++) begin
                  acc_hi[c] = acc_hi[c] + 16'(bus.out[c]);
               end
            end
            if (eop_d) begin
               if (rec_q.size() > 0) begin
                  r = rec_q.pop_front();
                  checks++;
                  rec_bad = (acc_len != r.len);
                  for (int c = 0; c < CH; c++) begin
                     if (acc_hi[c] != r.hi[c]) rec_bad = 1;
                  end
                  if (rec_bad) begin
                     errors++;
                     $display("FAIL %s: got len=%0d high=%0d,%0d,%0d,%0d, expected len=%0d high=%0d,%0d,%0d,%0d",
                              r.name, acc_len, acc_hi[0], acc_hi[1], acc_hi[2], acc_hi[3],
                              r.len, r.hi[0], r.hi[1], r.hi[2], r.hi[3]);
                  end
               end
               acc_len = 0;
               acc_hi  = '0;
            end
            if (bus.eop === 1'b1) eop_cnt++;
            eop_d   = bus.eop;
            en_prev = bus.en;
         end

         if (done) begin
            left = snap_q.size() + rec_q.size() + upd_q.size();
            checks++;
            if (left != 0) begin
               errors++;
               $display("FAIL leftover_expectations: got %0d unconsumed, expected 0", left);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator with double-buffered duty registers, a programmable period, and selectable edge- or center-aligned modulation. Duty words are streamed in over a valid/ready handshake into shadow registers. They are committed to all channels together at the next end-of-period, so no channel ever produces a torn period. The block sits between the frame-data path and the output drivers, and supersedes the fixed 8-channel, free-running PWM.

## Interface
- DWIDTH, 8: duty/period/counter width
- CHANNELS, 8: number of PWM outputs
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; 0 holds timebase and forces idle levels
- start  in  1  one-cycle pulse: begin load; samples period and mode
- period  in  DWIDTH  counter top P, sampled on accepted start
- mode  in  1  0 = edge-aligned, 1 = center-aligned, sampled on accepted start
- pol  in  CHANNELS  per-channel output inversion, applied live
- in_valid  in  1  duty word valid
- in_data  in  DWIDTH  duty word, channel 0 first
- in_ready  out  1  shadow accepting words
- busy  out  1  loader not IDLE
- eop  out  1  end-of-period pulse
- updated  out  1  pulse: new settings active this cycle
- out  out  CHANNELS  PWM outputs, registered

## Operation
- Loader FSM has three states:
  - IDLE: start → LOAD; idx=0; shadow period/mode captured.
  - LOAD: in_ready=1. Each in_valid&&in_ready writes shadow_duty[idx] and increments idx. Acceptance at idx=CHANNELS-1 → PEND.
  - PEND: in_ready=0. On eop, shadow duty/period/mode copy to active → IDLE.
- start in LOAD/PEND is ignored. A stalled in_valid holds idx indefinitely; there is no timeout.
- Edge mode: cnt runs 0,1,…,P,0,… (P+1 cycles). Raw output is cnt<duty.
- Center mode: cnt runs 0,1,…,P,P-1,…,1,0,… (2P cycles, up/down direction bit). Raw output is cnt<duty, giving 2·duty−1 high cycles centred on cnt=0.
- duty=0 → always inactive. duty>P → always active in both modes.
- P=0 → cnt stays 0; eop every cycle.
- eop asserts in the cycle whose next cnt is 0, i.e. the period restarts.
- If active period is lowered while cnt>P (only possible via commit at eop), the wrap still occurs normally. cnt is never >P after commit.
- out[i] = raw[i] ^ pol[i].
- en=0:
  - cnt is held at 0 and direction is set to up.
  - eop is held at 0.
  - out = pol.
  - The loader still accepts words; a PEND commit waits for en=1.

## Timing
- Reset values:
  - out=0, in_ready=0, busy=0, eop=0, updated=0
  - cnt=0, direction up, state IDLE, idx=0
  - active duty all 0, active period 2^DWIDTH−1, active mode edge
- out lags cnt by one cycle (registered compare).
- Accepted start → in_ready=1 the next cycle.
- Last word accepted → busy still 1 and in_ready=0 the next cycle.
- Commit: eop cycle t in PEND → active values valid and cnt=0 at t+1; updated=1 at t+1; busy=0 at t+1. New waveform appears on out at t+2.
- Last word accepted in the same cycle as eop → PEND is entered at t+1, and the commit waits for the following eop.
- rst at any point (mid-LOAD, mid-PEND) discards the shadow. Active values return to reset values.

## Structure
- Package pwm_pkg holds:
  - typedef enum load_state_t {IDLE, LOAD, PEND}
  - typedef enum pwm_mode_t {EDGE, CENTER}
- Sub-module pwm_timebase (clk, rst, en, period, mode → cnt, eop) contains the counter and direction bit.
- Per-channel compare/polarity registers are generated inline in pwm_bank.

## Test plan
All scenarios use DWIDTH=8, CHANNELS=4.
- Reset: rst 2 cycles → out=0000, busy=0, in_ready=0; with en=1 and no load, eop every 256 cycles; out stays 0000.
- Edge load: start with P=9, mode=0; duties 0,3,9,10 → after updated, per 10-cycle period ch0 high 0, ch1 3, ch2 9, ch3 10 cycles.
- Center load: P=4, mode=1, duty 2 on ch0 → ch0 high 3 contiguous cycles of every 8; eop spacing 8.
- Commit timing: last word accepted on an eop cycle → no change that period; updated pulses one cycle after the next eop; out changes one cycle after updated.
- Backpressure/restart: drop in_valid for 5 cycles mid-load → idx held, busy=1; start pulse during LOAD ignored (period not resampled).
- en/reset: en=0 with pol=0101 → out=0101 next cycle, no eop; rst during PEND → busy=0, active duties 0, pending words never applied.
